imem_fetch_ctrl: RTL
====================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequences the 2K-word instruction ROM (combinational read) for the 54-instruction CPU.
//  Owns the fetch PC and maps it to the ROM word index.
//  Presents one buffered instruction to decode via valid/ready, and honours branch/jump redirects.
//  Time-shares the ROM with a debug read port, with bounded wait for the debug requester.
// PARAMETERS
//  RESET_PC      32'h0040_0000  byte address of ROM word 0; fetch PC after reset
//  ADDR_W        11             ROM word-index width (window = 4*2^ADDR_W bytes)
//  BOOT_CYCLES   4              idle cycles after reset before first fetch (1..255)
//  DBG_WAIT_MAX  8              max cycles dbg_req waits before forced grant (1..255)
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       async reset, active-high
//  run_en          in   1       fetch enable; 0 = hold PC, no new fetches
//  redirect_valid  in   1       branch/jump/exception target valid this cycle
//  redirect_pc     in   32      new fetch byte address
//  out_valid       out  1       out_inst/out_pc hold a fetched instruction
//  out_ready       in   1       decode accepts (transfer = out_valid & out_ready)
//  out_inst        out  32      fetched instruction
//  out_pc          out  32      byte address of out_inst
//  pc              out  32      next fetch byte address
//  dbg_req         in   1       debug read request; level, held until dbg_gnt
//  dbg_addr        in   ADDR_W  debug ROM word index; stable while dbg_req
//  dbg_gnt         out  1       1-cycle pulse; dbg_data valid same cycle
//  dbg_data        out  32      ROM word read for debug; holds until next grant
//  imem_addr       out  ADDR_W  to ROM a; combinational
//  imem_inst       in   32      from ROM spo
//  fault           out  1       sticky: misaligned/out-of-window PC; cleared only by rst
// BEHAVIOUR
//  Reset (async): pc=RESET_PC; out_valid=0; out_inst=0; out_pc=0; dbg_gnt=0; dbg_data=0;
//   fault=0; state=BOOT; boot_cnt=0; wait_cnt=0.
//  States:
//   BOOT: no fetch, no debug; after BOOT_CYCLES cycles -> RUN.
//   RUN:  normal fetch; may enter DBG.
//   DBG:  exactly one cycle; ROM serves debug; -> RUN.
//  imem_addr = (state==DBG) ? dbg_addr : (pc-RESET_PC)[ADDR_W+1:2].
//  in_win = pc>=RESET_PC & pc<RESET_PC+(4<<ADDR_W) & pc[1:0]==0.
//  can_fetch = state==RUN & run_en & !fault & !redirect_valid & (!out_valid | out_ready).
//  Fetch (can_fetch & in_win), 0-cycle ROM latency, registered output next edge:
//   out_inst<=imem_inst; out_pc<=pc; out_valid<=1; pc<=pc+4.
//   Throughput: 1 instr/cycle when out_ready=1.
//  can_fetch & !in_win: fault<=1, no fetch, out_valid<=0 when consumed.
//   Sequential run off the window end faults on the next attempt.
//  Drain (out_valid & out_ready & no fetch): out_valid<=0.
//  Redirect (any state except BOOT), highest priority:
//   pc<=redirect_pc; out_valid<=0 (flush, even if out_ready); no fetch this cycle.
//   Misalignment/window checked at the next fetch attempt, not at capture.
//  Debug arbitration in RUN: go DBG when dbg_req & !dbg_gnt & (!can_fetch | wait_cnt==DBG_WAIT_MAX).
//   wait_cnt increments per cycle dbg_req is waiting in RUN; cleared on grant.
//  In DBG: dbg_data<=imem_inst; dbg_gnt<=1 next cycle (pulse).
//   No fetch in DBG; drain and redirect still act. DBG stalls fetch exactly one cycle.
//  dbg_req during BOOT waits (wait_cnt frozen); fault does not block debug reads.
//  Simultaneous redirect + debug entry: both happen; redirect wins the PC.
// STRUCTURE
//  imem_defs.vh: RESET_PC default, state encodings (BOOT/RUN/DBG), ADDR_W default.
//  Sub-module imem_addr_map: pc -> {word index, in_win}; combinational, reused by loader tools.
//  FSM + counters + output regs in this file.
// TESTING
//  Reset, BOOT_CYCLES=4, run_en=1, out_ready=1 -> first out_valid at cycle 5;
//   out_pc 0x00400000,0x00400004,... with out_inst = ROM[0],ROM[1],...
//  out_ready=0 for 3 cycles with out_valid=1 -> out_inst/out_pc/pc frozen;
//   resumes without loss or duplication.
//  redirect_pc=0x00400100 while out_valid=1 -> next cycle out_valid=0;
//   next fetch gives out_pc=0x00400100, inst ROM[64].
//  dbg_req addr 5 while out_ready=0 -> dbg_gnt pulse 2 cycles later, dbg_data=ROM[5], pc unchanged.
//  dbg_req with continuous fetch, DBG_WAIT_MAX=8 -> grant forced within 10 cycles;
//   exactly one fetch bubble.
//  redirect_pc=0x00400102 or 0x00402000 -> fault=1 at next fetch attempt, fetching stops;
//   debug reads still served; rst mid-run clears fault and restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// rtl/imem_fetch_ctrl_pkg.sv - shared defaults and state encoding for the instruction fetch controller
//
// Purpose: default ROM base / window size, counter width and the fetch FSM
// state type, shared by the fetch controller and its address-map helper.
// Ports: none (package).
package imem_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam int          ADDR_W_DEF   = 11;
  localparam int          CNT_W        = 8;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_addr_map.sv
// rtl/imem_fetch_ctrl_addr_map.sv - byte PC to ROM word index and window check
//
// Purpose: combinational map of a fetch byte address onto the ROM word index,
// plus an in-window flag (inside the ROM window and word aligned).
// Ports:
//   pc_i        in  32      byte address
//   word_idx_o  out ADDR_W  ROM word index ((pc - RESET_PC) >> 2, truncated)
//   in_win_o    out 1       pc lies inside the ROM window and is word aligned
module imem_fetch_ctrl_addr_map
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = ADDR_W_DEF
) (
  input  logic [31:0]       pc_i,
  output logic [ADDR_W-1:0] word_idx_o,
  output logic              in_win_o
);

  // Window size in bytes, one bit wider so ADDR_W up to 30 cannot overflow.
  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_W;

  logic [31:0] offset;

  assign offset     = pc_i - RESET_PC;
  assign word_idx_o = offset[ADDR_W+1:2];
  // The pc >= RESET_PC term rejects addresses below the base, whose offset wraps.
  assign in_win_o   = (pc_i >= RESET_PC) && ({1'b0, offset} < WIN_BYTES) &&
                      (pc_i[1:0] == 2'b00);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction ROM fetch sequencer with buffered output and debug read port
//
// Purpose: owns the fetch PC, reads the combinational instruction ROM and holds
// one fetched instruction for decode (valid/ready), honours redirects, and
// time-shares the ROM with a debug read port whose wait is bounded.
// Ports:
//   clk, rst             clock, async active-high reset
//   run_en               fetch enable (0 holds PC)
//   redirect_valid/_pc   branch/jump target, highest priority
//   out_valid/_ready     decode handshake; out_inst/out_pc hold the instruction
//   pc                   next fetch byte address
//   dbg_req/_addr        debug ROM read request (level) and word index
//   dbg_gnt/_data        1-cycle grant pulse and read data (held)
//   imem_addr/imem_inst  ROM address (combinational) and data
//   fault                sticky misaligned/out-of-window fetch flag
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int          ADDR_W       = ADDR_W_DEF,
  parameter int          BOOT_CYCLES  = 4,
  parameter int          DBG_WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic [31:0]       pc,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic [31:0]       dbg_data,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  output logic              fault
);

  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(DBG_WAIT_MAX);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic [31:0]      out_pc_q, out_pc_d;
  logic             dbg_gnt_q, dbg_gnt_d;
  logic [31:0]      dbg_data_q, dbg_data_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [ADDR_W-1:0] map_idx;
  logic              map_in_win;
  logic              can_fetch;
  logic              do_fetch;
  logic              dbg_enter;
  logic              redirect_act;

  imem_fetch_ctrl_addr_map #(
    .RESET_PC (RESET_PC),
    .ADDR_W   (ADDR_W)
  ) u_addr_map (
    .pc_i       (pc_q),
    .word_idx_o (map_idx),
    .in_win_o   (map_in_win)
  );

  assign imem_addr = (state_q == ST_DBG) ? dbg_addr : map_idx;

  assign can_fetch    = (state_q == ST_RUN) && run_en && !fault_q && !redirect_valid &&
                        (!out_valid_q || out_ready);
  assign do_fetch     = can_fetch && map_in_win;
  assign redirect_act = redirect_valid && (state_q != ST_BOOT);
  // Debug takes the ROM at once when fetch is idle anyway; otherwise it waits
  // until the wait counter saturates and then forces one fetch bubble.
  assign dbg_enter    = (state_q == ST_RUN) && dbg_req && !dbg_gnt_q &&
                        (!can_fetch || (wait_cnt_q == WAIT_MAX));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    dbg_gnt_d   = 1'b0;
    dbg_data_d  = dbg_data_q;
    fault_d     = fault_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
        else                         boot_cnt_d = boot_cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (dbg_enter) begin
          state_d    = ST_DBG;
          wait_cnt_d = '0;
        end else if (dbg_req && !dbg_gnt_q && (wait_cnt_q != WAIT_MAX)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DBG: begin
        state_d    = ST_RUN;
        dbg_data_d = imem_inst;
        dbg_gnt_d  = 1'b1;
        wait_cnt_d = '0;
      end
      default: state_d = ST_BOOT;
    endcase

    if (do_fetch) begin
      out_inst_d  = imem_inst;
      out_pc_d    = pc_q;
      out_valid_d = 1'b1;
      pc_d        = pc_q + 32'd4;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (can_fetch && !map_in_win) fault_d = 1'b1;

    // Redirect flushes the buffered instruction even if decode is taking it.
    if (redirect_act) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      dbg_gnt_q   <= 1'b0;
      dbg_data_q  <= '0;
      fault_q     <= 1'b0;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      dbg_gnt_q   <= dbg_gnt_d;
      dbg_data_q  <= dbg_data_d;
      fault_q     <= fault_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign pc        = pc_q;
  assign dbg_gnt   = dbg_gnt_q;
  assign dbg_data  = dbg_data_q;
  assign fault     = fault_q;

endmodule
